can_bit_rx: RTL and testbench

CAN_BIT_RX -- requirements
Module: can_bit_rx

---
 rtl/can_pkg.sv | 7 +
 rtl/can_bit_timing.sv | 61 ++++++
 rtl/can_bit_rx.sv | 75 +++++++
 tb/tb_can_bit_rx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// can_pkg: shared state types and constants for the CAN bit receiver
package can_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, FRAME} can_bit_rx_state_t;
  typedef enum logic [1:0] {SEG_SYNC, SEG_TS1, SEG_TS2} can_seg_t;
  localparam int CAN_IDLE_BITS = 11;
  localparam int CAN_STUFF_LEN = 5;
endpackage

// File: rtl/can_bit_timing.sv
// can_bit_timing: tq prescaler, segment counter with hard sync/resync and sample-point strobe
module can_bit_timing
  import can_pkg::*;
#(
  parameter int BRP   = 4,
  parameter int TSEG1 = 5,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic resync_en,
  input  logic hard_sync,
  input  logic fall,
  output logic sample
);
  can_seg_t   seg;
  logic [5:0] presc;
  logic [4:0] tq_cnt, late, rem, ts1_len, ts2_len, seg_len;
  logic [2:0] ext, ext_n, shr, shr_n;
  logic       done, tick, rs, restart, last;
  always_comb begin
    tick    = presc == 6'(BRP - 1);
    rs      = resync_en && fall && !hard_sync && seg != SEG_SYNC && !done;
    late    = tq_cnt + 5'd1;
    ext_n   = (rs && seg == SEG_TS1) ? (late > 5'(SJW) ? 3'(SJW) : late[2:0]) : ext;
    rem     = 5'(TSEG2) - 5'(shr) - tq_cnt;
    restart = rs && seg == SEG_TS2 && rem <= 5'(SJW);
    shr_n   = (rs && seg == SEG_TS2 && !restart) ? shr + 3'(SJW) : shr;
    ts1_len = 5'(TSEG1) + 5'(ext_n);
    ts2_len = 5'(TSEG2) - 5'(shr_n);
    seg_len = seg == SEG_SYNC ? 5'd1 : seg == SEG_TS1 ? ts1_len : ts2_len;
    last    = tick && tq_cnt == seg_len - 5'd1;
    // a resync edge on the sample clock wins; the lengthened phase1 moves the sample
    sample  = last && seg == SEG_TS1 && !rs;
  end
  // an early edge within SJW of the bit end simply starts the next bit now
  always_ff @(posedge clk)
    if (rst || hard_sync || restart) begin
      seg    <= SEG_SYNC;
      presc  <= '0;
      tq_cnt <= '0;
      ext    <= '0;
      shr    <= '0;
      done   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 6'd1;
      ext   <= ext_n;
      shr   <= shr_n;
      done  <= done || rs;
      if (last) begin
        tq_cnt <= '0;
        seg    <= seg == SEG_SYNC ? SEG_TS1 : seg == SEG_TS1 ? SEG_TS2 : SEG_SYNC;
        if (seg == SEG_TS2) begin
          ext  <= '0;
          shr  <= '0;
          done <= 1'b0;
        end
      end else if (tick) tq_cnt <= tq_cnt + 5'd1;
    end
endmodule

// File: rtl/can_bit_rx.sv
// can_bit_rx: CAN bit receiver with synchronizer, bus-state FSM and destuffer
module can_bit_rx
  import can_pkg::*;
#(
  parameter int BRP   = 4,
  parameter int TSEG1 = 5,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1
) (
  input  logic can_bit_rx_clk_i,
  input  logic can_bit_rx_rst_i,
  input  logic can_bit_rx_rx_i,
  input  logic can_bit_rx_destuff_en_i,
  output logic can_bit_rx_bit_o,
  output logic can_bit_rx_bit_valid_o,
  output logic can_bit_rx_sof_o,
  output logic can_bit_rx_stuff_err_o,
  output logic can_bit_rx_bus_idle_o
);
  can_bit_rx_state_t state, state_n;
  logic       s1, s2, s2_d, fall, hard_sync, sample, smp_frame, is_stuff, err_n, valid_n, rec_done;
  logic [3:0] rec_cnt;
  logic [2:0] run_len;
  logic       run_val;
  can_bit_timing #(.BRP(BRP), .TSEG1(TSEG1), .TSEG2(TSEG2), .SJW(SJW)) u_timing (
    .clk       (can_bit_rx_clk_i),
    .rst       (can_bit_rx_rst_i),
    .resync_en (state == FRAME),
    .hard_sync (hard_sync),
    .fall      (fall),
    .sample    (sample)
  );
  always_comb begin
    fall                  = s2_d && !s2;
    hard_sync             = state == IDLE && fall;
    smp_frame             = sample && state == FRAME;
    is_stuff              = can_bit_rx_destuff_en_i && run_len == 3'(CAN_STUFF_LEN);
    err_n                 = smp_frame && is_stuff && s2 == run_val;
    valid_n               = smp_frame && !is_stuff;
    rec_done              = sample && s2 && rec_cnt == 4'(CAN_IDLE_BITS - 1);
    state_n               = state == WAIT_IDLE ? (rec_done ? IDLE : WAIT_IDLE) :
                            state == IDLE      ? (fall ? FRAME : IDLE) :
                            err_n ? WAIT_IDLE : rec_done ? IDLE : FRAME;
    can_bit_rx_sof_o      = hard_sync;
    can_bit_rx_bus_idle_o = state == IDLE;
  end
  always_ff @(posedge can_bit_rx_clk_i)
    if (can_bit_rx_rst_i) begin
      state                  <= WAIT_IDLE;
      {s2_d, s2, s1}         <= 3'b111;
      rec_cnt                <= '0;
      run_len                <= '0;
      run_val                <= 1'b1;
      can_bit_rx_bit_o       <= 1'b1;
      can_bit_rx_bit_valid_o <= 1'b0;
      can_bit_rx_stuff_err_o <= 1'b0;
    end else begin
      state                  <= state_n;
      {s2_d, s2, s1}         <= {s2, s1, can_bit_rx_rx_i};
      can_bit_rx_bit_valid_o <= valid_n;
      can_bit_rx_stuff_err_o <= err_n;
      if (valid_n) can_bit_rx_bit_o <= s2;
      if (state_n != state) rec_cnt <= '0;
      else if (sample) rec_cnt <= s2 ? rec_cnt + 4'd1 : '0;
      // a stuff bit of the opposite level opens a fresh run of length 1
      if (state != FRAME || !can_bit_rx_destuff_en_i) run_len <= '0;
      else if (smp_frame) begin
        if (run_len != '0 && s2 == run_val && !is_stuff) run_len <= run_len + 3'd1;
        else begin
          run_len <= 3'd1;
          run_val <= s2;
        end
      end
    end
endmodule

// File: tb/tb_can_bit_rx.sv
// tb_can_bit_rx: directed scoreboard bench for the CAN bit receiver at 32 clocks per bit
module tb_can_bit_rx;
  logic clk = 1'b0;
  logic rst, rx, destuff_en;
  logic bit_o, bit_valid, sof, stuff_err, bus_idle;
  int   checks = 0, errors = 0, cyc = 0;
  int   n_valid, n_sof, n_err, sof_cyc, first_cyc, err_cyc, t0;
  logic exp_q[$];
  can_bit_rx dut (
    .can_bit_rx_clk_i        (clk),
    .can_bit_rx_rst_i        (rst),
    .can_bit_rx_rx_i         (rx),
    .can_bit_rx_destuff_en_i (destuff_en),
    .can_bit_rx_bit_o        (bit_o),
    .can_bit_rx_bit_valid_o  (bit_valid),
    .can_bit_rx_sof_o        (sof),
    .can_bit_rx_stuff_err_o  (stuff_err),
    .can_bit_rx_bus_idle_o   (bus_idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    n_valid = 0; n_sof = 0; n_err = 0;
    sof_cyc = -1; first_cyc = -1; err_cyc = -1;
    t0 = cyc;
  endtask
  task automatic cyc1();
    @(posedge clk);
    #1;
    cyc++;
    if (sof) begin n_sof++; sof_cyc = cyc; end
    if (stuff_err) begin n_err++; err_cyc = cyc; end
    if (bit_valid) begin
      n_valid++;
      if (first_cyc < 0) first_cyc = cyc;
      if (exp_q.size() > 0) chk("bit", 32'(bit_o), 32'(exp_q.pop_front()));
    end
  endtask
  task automatic send(input logic b, input int n);
    rx = b;
    repeat (n) cyc1();
  endtask
  initial begin
    rst = 1'b1; rx = 1'b1; destuff_en = 1'b1;
    repeat (3) cyc1();
    chk("rst_bit_o", bit_o, 1);
    chk("rst_valid", bit_valid, 0);
    chk("rst_sof", sof, 0);
    chk("rst_err", stuff_err, 0);
    chk("rst_idle", bus_idle, 0);
    rst = 1'b0;
    clr();
    repeat (300) cyc1();
    chk("idle_early", bus_idle, 0);
    repeat (56) cyc1();
    chk("idle_11_bits", bus_idle, 1);
    chk("idle_no_strobe", n_valid, 0);
    chk("idle_no_sof", n_sof, 0);
    chk("idle_no_err", n_err, 0);
    // SOF timing and destuffing: 0,0,0,0,0,1(stuff),1
    clr();
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    send(1'b0, 160);
    send(1'b1, 64);
    chk("sof_delay", sof_cyc - t0, 2);
    chk("first_valid_delay", first_cyc - t0, 27);
    chk("sof_count", n_sof, 1);
    chk("destuff_strobes", n_valid, 6);
    chk("frame_not_idle", bus_idle, 0);
    chk("destuff_no_err", n_err, 0);
    destuff_en = 1'b0;
    for (int i = 0; i < 9; i++) exp_q.push_back(1'b1);
    send(1'b1, 320);
    chk("nostuff_strobes", n_valid, 15);
    chk("frame_end_idle", bus_idle, 1);
    chk("queue_a", exp_q.size(), 0);
    // stuff violation on six dominant bits
    destuff_en = 1'b1;
    clr();
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b0);
    send(1'b0, 192);
    chk("err_delay", err_cyc - t0, 187);
    chk("err_count", n_err, 1);
    chk("err_strobes", n_valid, 5);
    chk("err_not_idle", bus_idle, 0);
    send(1'b1, 160);
    chk("err_wait_idle", bus_idle, 0);
    send(1'b1, 224);
    chk("err_recover_idle", bus_idle, 1);
    chk("err_strobes_after", n_valid, 5);
    chk("err_count_after", n_err, 1);
    chk("queue_b", exp_q.size(), 0);
    // slow sender (33 clocks/bit) with alternating bits
    clr();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(1'(i % 2));
      send(1'(i % 2), 33);
    end
    chk("slow_strobes", n_valid, 20);
    chk("slow_no_err", n_err, 0);
    chk("slow_sof", n_sof, 1);
    destuff_en = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(1'b1);
    send(1'b1, 384);
    chk("slow_total", n_valid, 30);
    chk("slow_idle", bus_idle, 1);
    chk("queue_c", exp_q.size(), 0);
    // reset in the middle of bit 3
    destuff_en = 1'b1;
    clr();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    send(1'b0, 32);
    send(1'b1, 32);
    send(1'b0, 32);
    send(1'b0, 10);
    chk("pre_reset_strobes", n_valid, 3);
    rst = 1'b1;
    cyc1();
    cyc1();
    chk("midrst_bit_o", bit_o, 1);
    chk("midrst_valid", bit_valid, 0);
    chk("midrst_idle", bus_idle, 0);
    rst = 1'b0;
    clr();
    send(1'b0, 22);
    send(1'b1, 160);
    chk("post_rst_wait", bus_idle, 0);
    send(1'b1, 256);
    chk("post_rst_idle", bus_idle, 1);
    chk("post_rst_strobes", n_valid, 0);
    chk("post_rst_sof", n_sof, 0);
    chk("post_rst_err", n_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
